// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection pixel path: FSM state
// encoding, pixel width and the pixel-index to byte-address shift.
package edge_pkg;

  localparam int PIXEL_W    = 24;
  localparam int ADDR_SHIFT = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    DONE     = 3'd3
`ifdef PIXEL_READ_TIMEOUT_EN
    , TIMEOUT = 3'd4
`endif
  } state_t;

  // Byte address of a pixel; the add wraps modulo 2^32 by construction.
  function automatic logic [31:0] pixel_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << ADDR_SHIFT);
  endfunction

endpackage

// File: rtl/rd_timer.sv
// Wait-cycle counter for the pixel read master; expired is high on the
// CYCLES-th consecutive enabled cycle and the count restarts on clear.
module rd_timer #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_reg;

  assign expired = enable && (cnt_reg == CW'(CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && !expired) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/pixel_read_master.sv
// Single-pixel memory read master: one request per accepted strobe, captures RGB.
// Optional ack timeout (TIMEOUT state, o_rd_error) enabled by PIXEL_READ_TIMEOUT_EN.
module pixel_read_master
  import edge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_re,
  input  logic [31:0]        i_raddr,
  input  logic               i_clear_err,
  output logic [31:0]        o_mem_addr,
  output logic               o_mem_rreq,
  input  logic               i_mem_rack,
  input  logic [31:0]        i_mem_rdata,
  output logic [PIXEL_W-1:0] o_pixel_data,
  output logic               o_read_complete,
  output logic               o_busy,
`ifdef PIXEL_READ_TIMEOUT_EN
  output logic               o_rd_error,
`endif
  output logic               o_overrun
);

  state_t state_reg, state_next;

  logic [31:0]        addr_reg;
  logic [PIXEL_W-1:0] pixel_reg;
  logic               complete_reg;
  logic               overrun_reg;
  logic               rreq;
  logic               busy;
  logic               re_accept;
  logic               capture;
  logic               finishing;
  logic               timeout_hit;
  logic               unused_rdata_hi;

  assign unused_rdata_hi = ^i_mem_rdata[31:PIXEL_W];

`ifdef PIXEL_READ_TIMEOUT_EN
  logic timer_expired;
  logic rd_error_reg;

  rd_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_rd_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .enable  (state_reg == WAIT_ACK),
    .clear   (state_reg != WAIT_ACK),
    .expired (timer_expired)
  );

  // An ack arriving on the expiry cycle still wins over the timeout.
  assign timeout_hit = (state_reg == WAIT_ACK) && !i_mem_rack && timer_expired;
  assign finishing   = (state_reg == DONE) || (state_reg == TIMEOUT);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign finishing   = (state_reg == DONE);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (re_accept) state_next = ISSUE;
      ISSUE:    state_next = i_mem_rack ? DONE : WAIT_ACK;
      WAIT_ACK: begin
        if (i_mem_rack) state_next = DONE;
`ifdef PIXEL_READ_TIMEOUT_EN
        else if (timeout_hit) state_next = TIMEOUT;
`endif
      end
      default:  state_next = IDLE;
    endcase
  end

  // The completion pulse is registered, so busy also covers that cycle.
  always_comb begin
    rreq = 1'b0;
    busy = complete_reg;
    case (state_reg)
      IDLE:            ;
      ISSUE, WAIT_ACK: begin
        rreq = 1'b1;
        busy = 1'b1;
      end
      default:         busy = 1'b1;
    endcase
    re_accept = i_re && !busy;
    capture   = rreq && i_mem_rack;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_reg     <= '0;
      pixel_reg    <= '0;
      complete_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      if (re_accept) addr_reg <= pixel_addr(BASE_ADDR, i_raddr);
      if (capture)          pixel_reg <= i_mem_rdata[PIXEL_W-1:0];
      else if (timeout_hit) pixel_reg <= '0;
      complete_reg <= finishing;
      overrun_reg  <= (i_re && busy) || (overrun_reg && !i_clear_err);
    end
  end

`ifdef PIXEL_READ_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rd_error_reg <= 1'b0;
    else        rd_error_reg <= timeout_hit || (rd_error_reg && !i_clear_err);
  end

  assign o_rd_error = rd_error_reg;
`endif

  assign o_mem_addr      = addr_reg;
  assign o_mem_rreq      = rreq;
  assign o_pixel_data    = pixel_reg;
  assign o_read_complete = complete_reg;
  assign o_busy          = busy;
  assign o_overrun       = overrun_reg;

endmodule

// File: tb/tb_pixel_read_master.sv
// Randomized bench for pixel_read_master against a transaction-level model
// (address arithmetic, latency = 3 + ack delay, sticky overrun).
module tb_pixel_read_master;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_re;
  logic [31:0] i_raddr;
  logic        i_clear_err;
  logic        i_mem_rack;
  logic [31:0] i_mem_rdata;

  logic [31:0] o_mem_addr, d1_mem_addr;
  logic        o_mem_rreq, d1_mem_rreq;
  logic [23:0] o_pixel_data, d1_pixel_data;
  logic        o_read_complete, d1_read_complete;
  logic        o_busy, d1_busy;
  logic        o_overrun, d1_overrun;
`ifdef PIXEL_READ_TIMEOUT_EN
  logic        o_rd_error, d1_rd_error;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] pix_exp;
  logic        ovr_exp;

  always #5 clk = ~clk;

  pixel_read_master #(.BASE_ADDR(BASE0), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .n_rst(n_rst), .i_re(i_re), .i_raddr(i_raddr), .i_clear_err(i_clear_err),
    .o_mem_addr(o_mem_addr), .o_mem_rreq(o_mem_rreq), .i_mem_rack(i_mem_rack),
    .i_mem_rdata(i_mem_rdata), .o_pixel_data(o_pixel_data),
    .o_read_complete(o_read_complete), .o_busy(o_busy),
`ifdef PIXEL_READ_TIMEOUT_EN
    .o_rd_error(o_rd_error),
`endif
    .o_overrun(o_overrun)
  );

  pixel_read_master #(.BASE_ADDR(BASE1), .TIMEOUT_CYCLES(64)) dut_wrap (
    .clk(clk), .n_rst(n_rst), .i_re(i_re), .i_raddr(i_raddr), .i_clear_err(i_clear_err),
    .o_mem_addr(d1_mem_addr), .o_mem_rreq(d1_mem_rreq), .i_mem_rack(i_mem_rack),
    .i_mem_rdata(i_mem_rdata), .o_pixel_data(d1_pixel_data),
    .o_read_complete(d1_read_complete), .o_busy(d1_busy),
`ifdef PIXEL_READ_TIMEOUT_EN
    .o_rd_error(d1_rd_error),
`endif
    .o_overrun(d1_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] idx, input int dly, input logic [31:0] word,
                         input bit probe_busy, input bit clr_with_probe, input bit probe_done);
    int lat;
    bit seen;
    logic [31:0] a0, a1;
    a0 = BASE0 + idx * 4;
    a1 = BASE1 + idx * 4;
    i_re = 1'b1; i_raddr = idx;
    tick; lat = 1;
    i_re = 1'b0; i_raddr = $urandom;
    check("rreq_rise", {31'd0, o_mem_rreq}, 1);
    check("addr", o_mem_addr, a0);
    check("addr_wrap", d1_mem_addr, a1);
    check("busy", {31'd0, o_busy}, 1);
    check("pix_hold", {8'd0, o_pixel_data}, {8'd0, pix_exp});
    if (probe_busy) begin
      i_re = 1'b1;
      i_clear_err = clr_with_probe;
      ovr_exp = 1'b1;
    end
    for (int k = 0; k < dly; k++) begin
      tick; lat++;
      i_re = 1'b0; i_clear_err = 1'b0;
      check("rreq_hold", {31'd0, o_mem_rreq}, 1);
      check("addr_hold", o_mem_addr, a0);
    end
    i_mem_rack = 1'b1; i_mem_rdata = word;
    tick; lat++;
    i_mem_rack = 1'b0; i_mem_rdata = $urandom; i_re = 1'b0; i_clear_err = 1'b0;
    pix_exp = word[23:0];
    check("rreq_drop", {31'd0, o_mem_rreq}, 0);
    seen = 1'b0;
    while (!seen && lat < 12) begin
      if (o_read_complete) seen = 1'b1;
      else begin tick; lat++; end
    end
    check("complete_seen", {31'd0, seen}, 1);
    check("latency", lat, 3 + dly);
    check("pixel", {8'd0, o_pixel_data}, {8'd0, pix_exp});
    check("busy_done", {31'd0, o_busy}, 1);
    if (probe_done) begin
      i_re = 1'b1;
      ovr_exp = 1'b1;
    end
    tick;
    i_re = 1'b0;
    check("pulse_one", {31'd0, o_read_complete}, 0);
    check("no_reissue", {31'd0, o_mem_rreq}, 0);
    check("idle", {31'd0, o_busy}, 0);
    check("overrun", {31'd0, o_overrun}, {31'd0, ovr_exp});
    $display("read idx=0x%08h dly=%0d word=0x%08h lat=%0d pix=0x%06h ovr=%0b",
             idx, dly, word, lat, o_pixel_data, o_overrun);
  endtask

  task automatic clear_err;
    i_clear_err = 1'b1;
    tick;
    i_clear_err = 1'b0;
    ovr_exp = 1'b0;
    check("ovr_clr", {31'd0, o_overrun}, 0);
    $display("clear_err ovr=%0b", o_overrun);
  endtask

  task automatic stray_ack;
    i_mem_rack = 1'b1; i_mem_rdata = $urandom;
    tick;
    i_mem_rack = 1'b0;
    check("stray_pix", {8'd0, o_pixel_data}, {8'd0, pix_exp});
    check("stray_cmp", {31'd0, o_read_complete}, 0);
    $display("stray ack pix=0x%06h", o_pixel_data);
  endtask

  task automatic reset_mid_wait(input logic [31:0] idx);
    i_re = 1'b1; i_raddr = idx;
    tick;
    i_re = 1'b0;
    tick;
    #2 n_rst = 1'b0;
    #1;
    check("rst_addr", o_mem_addr, 0);
    check("rst_pix", {8'd0, o_pixel_data}, 0);
    check("rst_rreq", {31'd0, o_mem_rreq}, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_ovr", {31'd0, o_overrun}, 0);
    i_mem_rack = 1'b1; i_mem_rdata = 32'h00FF_EEDD;
    tick;
    n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("late_ack_cmp", {31'd0, o_read_complete}, 0);
      check("late_ack_pix", {8'd0, o_pixel_data}, 0);
      check("late_ack_rreq", {31'd0, o_mem_rreq}, 0);
    end
    i_mem_rack = 1'b0;
    pix_exp = '0;
    ovr_exp = 1'b0;
    $display("reset during wait: pix=0x%06h cmp=%0b", o_pixel_data, o_read_complete);
  endtask

`ifdef PIXEL_READ_TIMEOUT_EN
  task automatic timeout_read(input logic [31:0] idx);
    int cnt;
    int pulses;
    i_re = 1'b1; i_raddr = idx;
    tick;
    i_re = 1'b0;
    cnt = 0;
    while (o_mem_rreq && cnt < 200) begin tick; cnt++; end
    check("to_window", {31'd0, (cnt >= 64 && cnt <= 66)}, 1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (o_read_complete) pulses++;
      if (k == 1) begin
        check("to_err", {31'd0, o_rd_error}, 1);
        check("to_pix", {8'd0, o_pixel_data}, 0);
      end
      tick;
    end
    check("to_pulses", pulses, 1);
    pix_exp = '0;
    $display("timeout read rreq_cycles=%0d pulses=%0d err=%0b", cnt, pulses, o_rd_error);
  endtask
`endif

  initial begin
    logic [31:0] idx, word;
    int dly;
    bit pb, pc, pd;
    n_rst = 1'b0; i_re = 1'b0; i_raddr = '0; i_clear_err = 1'b0;
    i_mem_rack = 1'b0; i_mem_rdata = '0;
    pix_exp = '0; ovr_exp = 1'b0;
    #1;
    check("reset_addr", o_mem_addr, 0);
    check("reset_rreq", {31'd0, o_mem_rreq}, 0);
    check("reset_busy", {31'd0, o_busy}, 0);
    check("reset_cmp", {31'd0, o_read_complete}, 0);
    check("reset_pix", {8'd0, o_pixel_data}, 0);
    check("reset_ovr", {31'd0, o_overrun}, 0);
    tick; tick;
    n_rst = 1'b1;
    tick;

    do_read(32'd5, 1, 32'h00A0_B0C0, 0, 0, 0);
    do_read(32'd17, 0, 32'h1234_5678, 0, 0, 0);
    do_read(32'd9, 1, 32'hFF11_2233, 1, 0, 0);
    clear_err();
    do_read(32'd8, 2, 32'h0055_AA55, 1, 1, 0);
    clear_err();
    do_read(32'd3, 0, 32'h0001_0203, 0, 0, 1);
    clear_err();
    stray_ack();

    for (int t = 0; t < 24; t++) begin
      idx  = $urandom;
      dly  = $urandom_range(0, 4);
      word = $urandom;
      pb   = ($urandom_range(0, 3) == 0);
      pc   = pb && ($urandom_range(0, 1) == 1);
      pd   = ($urandom_range(0, 3) == 0);
      do_read(idx, dly, word, pb, pc, pd);
      if ($urandom_range(0, 2) == 0) clear_err();
      if ($urandom_range(0, 3) == 0) stray_ack();
    end

    reset_mid_wait(32'd42);
`ifdef PIXEL_READ_TIMEOUT_EN
    timeout_read(32'd7);
    do_read(32'd11, 1, 32'h00C0_FFEE, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
